// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction cache miss handler: stalls fetch, fetches the missing line, writes it into the cache
module icache_refill #(
  parameter int ADDR_SIZE         = 32,
  parameter int ICACHE_LINE_SIZE  = 32,
  parameter int ILINE_BYTE_OFFSET = 1,
  parameter int TIMEOUT           = 64,
  parameter int CNT_W             = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  input  logic [ADDR_SIZE-1:0]        pc_i,
  input  logic                        hit_i,
  input  logic                        flush_i,
  output logic                        stall_o,
  output logic                        cache_we_o,
  output logic [ADDR_SIZE-1:0]        cache_addr_o,
  output logic [ICACHE_LINE_SIZE-1:0] cache_line_o,
  output logic                        mem_req_o,
  output logic [ADDR_SIZE-1:0]        mem_addr_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [ICACHE_LINE_SIZE-1:0] mem_rdata_i,
  input  logic                        mem_err_i,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [CNT_W-1:0]            miss_cnt_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_SIZE-1:0] LINE_MASK = {ADDR_SIZE{1'b1}} << (ILINE_BYTE_OFFSET + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t                        state_q, state_d;
  logic [ADDR_SIZE-1:0]          line_addr_q;
  logic [ICACHE_LINE_SIZE-1:0]   data_q;
  logic [TW-1:0]                 tcnt_q;
  logic [CNT_W-1:0]              miss_cnt_q;
  logic                          err_q;
  logic                          miss;

  assign miss = req_valid_i & ~hit_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      line_addr_q <= '0;
      data_q      <= '0;
      tcnt_q      <= '0;
      miss_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && miss) begin
        line_addr_q <= pc_i & LINE_MASK;
        if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
      if (state_q == S_REQ && mem_gnt_i) tcnt_q <= '0;
      else if (state_q == S_WAIT || state_q == S_DRAIN) tcnt_q <= tcnt_q + 1'b1;
      if (state_q == S_WAIT && mem_rvalid_i && !mem_err_i) data_q <= mem_rdata_i;
      if (state_d == S_ERR) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    cache_we_o = 1'b0;
    unique case (state_q)
      S_IDLE: if (miss) state_d = S_REQ;
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = flush_i ? S_DRAIN : S_WAIT;
        else if (flush_i) state_d = S_IDLE;
      end
      S_WAIT: begin
        // a bus error outranks data returned in the same cycle
        if (mem_err_i) state_d = S_ERR;
        else if (mem_rvalid_i) state_d = flush_i ? S_DRAIN : S_FILL;
        else if (flush_i) state_d = S_DRAIN;
        else if (tcnt_q == T_LAST) state_d = S_ERR;
      end
      S_FILL: begin
        cache_we_o = 1'b1;
        state_d    = S_IDLE;
      end
      S_DRAIN: if (mem_rvalid_i || mem_err_i || tcnt_q == T_LAST) state_d = S_IDLE;
      S_ERR: if (flush_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign stall_o      = miss | busy_o;
  assign mem_addr_o   = line_addr_q;
  assign cache_addr_o = line_addr_q;
  assign cache_line_o = data_q;
  assign err_o        = err_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - self-checking bench for icache_refill using a transaction-timeline reference model
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic [31:0] pc_i;
  logic        hit_i;
  logic        flush_i;
  logic        stall_o;
  logic        cache_we_o;
  logic [31:0] cache_addr_o;
  logic [31:0] cache_line_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        busy_o;
  logic        err_o;
  logic [3:0]  miss_cnt_o;

  int checks = 0;
  int errors = 0;
  int model_misses = 0;

  icache_refill #(.CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .pc_i(pc_i), .hit_i(hit_i),
    .flush_i(flush_i), .stall_o(stall_o), .cache_we_o(cache_we_o), .cache_addr_o(cache_addr_o),
    .cache_line_o(cache_line_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i), .busy_o(busy_o), .err_o(err_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i = 0; hit_i = 0; flush_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = $urandom;
  endtask

  function automatic logic [31:0] exp_cnt();
    return (model_misses > 15) ? 32'd15 : 32'(model_misses);
  endfunction

  // kind 0: normal refill, 1: flush while waiting, 2: flush while request not granted
  task automatic refill(input logic [31:0] pc, input int gd, input int rd, input int kind,
                        input int fpos, input logic [31:0] rdata, output int stall_cycles);
    logic [31:0] line;
    int t_gnt, t_rv, t_flush, t_end, req_end;
    bit busy_e, stall_e, we_e, in_req;
    line    = pc & 32'hFFFF_FFFC;
    t_gnt   = 1 + gd;
    t_rv    = 2 + gd + rd;
    t_flush = (kind == 1) ? 2 + gd + fpos : 1 + fpos;
    t_end   = (kind == 0) ? t_rv + 2 : (kind == 1) ? t_rv + 1 : 2 + fpos;
    req_end = (kind == 2) ? 1 + fpos : t_gnt;
    stall_cycles = 0;
    model_misses++;
    for (int c = 0; c <= t_end; c++) begin
      idle_inputs();
      req_valid_i  = (c == 0);
      pc_i         = pc;
      mem_gnt_i    = (kind != 2) && (c == t_gnt);
      mem_rvalid_i = (kind != 2) && (c == t_rv);
      if (c == t_rv) mem_rdata_i = rdata;
      flush_i      = (kind != 0) && (c == t_flush);
      #2;
      in_req  = (c >= 1) && (c <= req_end);
      busy_e  = (c >= 1) && (c < t_end);
      stall_e = (c == 0) || busy_e;
      we_e    = (kind == 0) && (c == t_rv + 1);
      if (stall_o) stall_cycles++;
      chk("stall", stall_o, stall_e);
      chk("busy", busy_o, busy_e);
      chk("mem_req", mem_req_o, in_req);
      if (in_req) chk("mem_addr", mem_addr_o, line);
      chk("cache_we", cache_we_o, we_e);
      if (we_e) begin
        chk("cache_addr", cache_addr_o, line);
        chk("cache_line", cache_line_o, rdata);
      end
      if (c == 1) chk("miss_cnt", miss_cnt_o, exp_cnt());
      chk("err", err_o, 0);
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    next_cycle();
    rst_i = 0;
    model_misses = 0;
  endtask

  initial begin
    int sc, gd, rd, kind, fpos;
    rst_i = 1; pc_i = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", miss_cnt_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", cache_we_o, 0);
    chk("rst_maddr", mem_addr_o, 0);
    chk("rst_cline", cache_line_o, 0);
    rst_i = 0;
    next_cycle();

    // hit path
    for (int i = 0; i < 10; i++) begin
      req_valid_i = 1; hit_i = 1; pc_i = $urandom;
      #2;
      chk("hit_stall", stall_o, 0);
      chk("hit_req", mem_req_o, 0);
      next_cycle();
    end
    idle_inputs();
    chk("hit_cnt", miss_cnt_o, 0);

    // cold miss, rvalid three cycles after grant
    refill(32'h0000_0104, 0, 2, 0, 0, 32'h0010_0093, sc);
    chk("cold_stall_cycles", sc, 6);
    chk("cold_cnt", miss_cnt_o, 1);

    // grant backpressure
    refill(32'h0000_0200, 5, 1, 0, 0, $urandom, sc);
    // flush while waiting, response arrives later
    refill(32'h0000_0310, 0, 3, 1, 1, $urandom, sc);

    // bus error takes priority over rvalid; ERR holds until flush
    pc_i = 32'h0000_0302; req_valid_i = 1; model_misses++;
    next_cycle();
    idle_inputs(); mem_gnt_i = 1;
    next_cycle();
    idle_inputs(); mem_err_i = 1; mem_rvalid_i = 1;
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("err_set", err_o, 1);
      chk("err_stall", stall_o, 1);
      chk("err_we", cache_we_o, 0);
      next_cycle();
    end
    flush_i = 1;
    next_cycle();
    idle_inputs();
    #2;
    chk("err_exit_busy", busy_o, 0);
    chk("err_sticky", err_o, 1);
    chk("err_exit_stall", stall_o, 0);
    next_cycle();

    // timeout: ERR exactly 64 cycles after the grant edge
    do_reset();
    pc_i = 32'h0000_0500; req_valid_i = 1; model_misses++;
    next_cycle();
    idle_inputs(); mem_gnt_i = 1;
    next_cycle();
    idle_inputs();
    for (int w = 0; w < 64; w++) begin
      #2;
      if (w == 0 || w == 63) begin
        chk("to_wait_err", err_o, 0);
        chk("to_wait_busy", busy_o, 1);
      end
      next_cycle();
    end
    #2;
    chk("to_err", err_o, 1);
    flush_i = 1;
    next_cycle();

    // reset mid-refill, then a stray response must be ignored
    do_reset();
    pc_i = 32'h0000_0400; req_valid_i = 1;
    next_cycle();
    idle_inputs(); mem_gnt_i = 1;
    next_cycle();
    idle_inputs(); rst_i = 1;
    next_cycle();
    rst_i = 0; model_misses = 0;
    #2;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_maddr", mem_addr_o, 0);
    chk("mid_rst_cnt", miss_cnt_o, 0);
    chk("mid_rst_err", err_o, 0);
    mem_rvalid_i = 1;
    next_cycle();
    idle_inputs();
    #2;
    chk("stray_we", cache_we_o, 0);
    chk("stray_busy", busy_o, 0);
    next_cycle();

    // randomized refills, also driving the counter into saturation
    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 2);
      gd   = $urandom_range(0, 4);
      rd   = $urandom_range(0, 5);
      fpos = 0;
      if (kind == 1) begin
        if (rd == 0) rd = 1;
        fpos = $urandom_range(0, rd - 1);
      end else if (kind == 2) begin
        if (gd == 0) gd = 1;
        fpos = $urandom_range(0, gd - 1);
      end
      refill($urandom, gd, rd, kind, fpos, $urandom, sc);
    end
    chk("sat_cnt", miss_cnt_o, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss handler directly upstream of the instruction cache's write port.
- Watches the fetch lookup (pc, hit) and stalls fetch on a miss.
- Fetches the missing line from backing instruction memory over a req/gnt + rvalid handshake.
- Writes the returned line into the cache in a single write cycle, then releases fetch to replay the lookup.

Parameters:
ADDR_SIZE, 32, fetch/memory address width
ICACHE_LINE_SIZE, 32, cache line width in bits (one instruction)
ILINE_BYTE_OFFSET, 1, MSB index of the byte-offset field; address bits [ILINE_BYTE_OFFSET:0] are cleared to form line address
TIMEOUT, 64, max cycles in WAIT before error
CNT_W, 16, miss counter width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  1  fetch lookup valid this cycle
pc_i  in  ADDR_SIZE  fetch address
hit_i  in  1  cache hit for pc_i this cycle
flush_i  in  1  pipeline redirect; cancels outstanding refill
stall_o  out  1  hold fetch
cache_we_o  out  1  cache write strobe
cache_addr_o  out  ADDR_SIZE  cache write address (line aligned)
cache_line_o  out  ICACHE_LINE_SIZE  cache write data
mem_req_o  out  1  memory request
mem_addr_o  out  ADDR_SIZE  memory request address (line aligned)
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  ICACHE_LINE_SIZE  read data
mem_err_i  in  1  bus error (same timing as rvalid)
busy_o  out  1  state != IDLE
err_o  out  1  sticky refill error
miss_cnt_o  out  CNT_W  saturating miss count

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE; addr/data regs=0; timeout cnt=0; miss_cnt_o=0; err_o=0. All strobes (cache_we_o, mem_req_o) are 0 and busy_o=0 while in IDLE.
- miss = req_valid_i & ~hit_i & ~flush_i.
- stall_o (combinational) = miss | (state != IDLE).
- States and transitions:
  - IDLE:
    - On miss: latch line_addr = pc_i with bits [ILINE_BYTE_OFFSET:0] cleared; miss_cnt_o += 1 (saturates at all-ones); next = REQ.
    - Otherwise stay.
  - REQ:
    - mem_req_o=1, mem_addr_o=line_addr; both held stable until grant.
    - mem_gnt_i=1 -> WAIT, timeout cnt cleared.
    - flush_i=1 with mem_gnt_i=0 -> IDLE, request dropped.
    - flush_i=1 with mem_gnt_i=1 -> DRAIN.
  - WAIT:
    - mem_req_o=0; timeout cnt increments each cycle.
    - mem_err_i=1 -> ERR (takes priority over rvalid).
    - Otherwise mem_rvalid_i=1 -> latch mem_rdata_i; next = FILL, or DRAIN if flush_i is high in the same cycle (data discarded, next = IDLE via DRAIN exit rule).
    - flush_i=1 with no response -> DRAIN.
    - Timeout cnt reaching TIMEOUT-1 with no response -> ERR.
  - FILL: one cycle; cache_we_o=1, cache_addr_o=line_addr, cache_line_o=latched data; next = IDLE. flush_i does not suppress the write (data is correct for line_addr).
  - DRAIN: wait for mem_rvalid_i or mem_err_i, discard, next = IDLE; no cache write, err_o unaffected. Timeout also applies in DRAIN; on expiry next = IDLE silently.
  - ERR: err_o=1 (sticky); stall_o=1. Leaves only on flush_i (-> IDLE, err_o stays 1) or rst_i. err_o is cleared only by rst_i.
- Latency: miss in cycle 0 -> REQ in cycle 1. With gnt in cycle 1 and rvalid in cycle 1+L, FILL is at cycle 2+L and IDLE at cycle 3+L; fetch replays then.
- Outputs outside their owning state are driven to 0 (cache_addr_o, cache_line_o and mem_addr_o may hold the last value).
- One outstanding request maximum. mem_rvalid_i outside WAIT/DRAIN is ignored.
- rst_i mid-refill: returns to IDLE immediately; any in-flight response is ignored. The memory side must tolerate an abandoned request.

Test Plan:
- Cold miss: pc_i=0x0000_0104, hit_i=0, gnt same cycle, rvalid after 3 cycles with rdata=0x0010_0093 -> mem_addr_o=0x104; one cycle cache_we_o=1, addr=0x104, line=0x0010_0093; stall_o high for 6 cycles; miss_cnt_o=1.
- Hit path: req_valid_i=1, hit_i=1 for 10 cycles -> stall_o=0, mem_req_o never asserted, miss_cnt_o=0.
- Grant backpressure: miss at 0x200, mem_gnt_i low 5 cycles -> mem_req_o and mem_addr_o=0x200 stable for 5 cycles, WAIT entered on cycle 6.
- Flush in WAIT: flush_i pulse while waiting, then rvalid -> no cache_we_o; busy_o falls the cycle after rvalid; err_o=0.
- Error and timeout: (a) mem_err_i=1 in WAIT -> err_o=1, stall_o held until flush_i. (b) no rvalid for TIMEOUT=64 cycles -> ERR entered exactly 64 cycles after grant.
- Reset mid-refill and saturation: rst_i=1 in WAIT -> next cycle IDLE, all outputs 0. With CNT_W=4, 20 misses -> miss_cnt_o=15.
